// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit with a built-in program loader. After reset the block
// sits in a load phase and writes incoming program words into the instruction
// memory at consecutive word addresses starting at LOAD_BASE. A load_done pulse
// ends the load phase. The block then fetches instructions one at a time from
// RESET_PC onwards and hands each one to decode with a valid/ready handshake.
// A redirect from the branch unit replaces the PC and cancels any fetch in
// progress.
//
// The instruction memory has a one-cycle read latency. Each fetch therefore
// takes three states:
//   S_REQ  : present the read address
//   S_RESP : capture the returned word into the output registers
//   S_OUT  : hold the instruction until decode accepts it
// This gives a peak rate of one instruction every three cycles.
//
// Parameters
//   RESET_PC   byte PC of the first fetch after loading completes
//   LOAD_BASE  byte address of the first word written during load
//
// Ports
//   clk             single clock, all logic on the rising edge
//   reset           synchronous, active-high reset
//   load_valid      program word present on load_data
//   load_data       program word to write into imem
//   load_ready      loader accepts a word this cycle
//   load_done       one-cycle pulse that ends the load phase
//   imem_address    word index to imem (byte address >> 2)
//   imem_rw         1 = read, 0 = write
//   imem_data_in    write data to imem
//   imem_data_out   read data from imem, valid one cycle after the address
//   redirect_valid  branch/jump redirect request
//   redirect_pc     new byte PC, bits [1:0] ignored
//   instr_valid     instr/instr_pc hold a fetched instruction
//   instr_ready     decode accepts the instruction
//   instr           fetched instruction word
//   instr_pc        byte PC of instr
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        load_done,
    output logic [31:0] imem_address,
    output logic        imem_rw,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_REQ,
        S_RESP,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_load_ptr;
    logic [31:0] w_load_ptr_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_instr_pc;
    logic [31:0] w_instr_pc_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic        w_load_fire;
    logic        w_redirect;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_pc          <= RESET_PC;
            r_load_ptr    <= LOAD_BASE;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_load_ptr    <= w_load_ptr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // Redirects only matter once fetching has started; the loader ignores them.
    assign w_redirect = redirect_valid && (r_state != S_LOAD);

    // load_ready follows load_valid in the load phase, so a presented word is
    // always accepted and written in the same cycle.
    assign w_load_fire = (r_state == S_LOAD) && load_valid && !reset;

    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_load_ptr_nxt    = r_load_ptr;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        load_ready        = 1'b0;
        imem_rw           = 1'b1;
        imem_address      = {2'b00, r_pc[31:2]};
        imem_data_in      = '0;

        case (r_state)
            S_LOAD: begin
                load_ready   = load_valid;
                imem_rw      = ~load_valid;
                imem_address = {2'b00, r_load_ptr[31:2]};
                imem_data_in = load_data;
                if (w_load_fire) begin
                    w_load_ptr_nxt = r_load_ptr + 32'd4;
                end
                // The word presented alongside load_done is still written above.
                if (load_done) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = RESET_PC;
                end
            end

            S_REQ: begin
                w_state_nxt = S_RESP;
            end

            S_RESP: begin
                // Read data for the address presented in S_REQ is valid now.
                w_instr_nxt       = imem_data_out;
                w_instr_pc_nxt    = r_pc;
                w_instr_valid_nxt = 1'b1;
                w_pc_nxt          = r_pc + 32'd4;
                w_state_nxt       = S_OUT;
            end

            S_OUT: begin
                if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        // A redirect wins over everything above, including a same-cycle
        // handshake in S_OUT and the capture in S_RESP: the word in flight
        // belongs to the old path and is dropped.
        if (w_redirect) begin
            w_pc_nxt          = redirect_pc & ~32'd3;
            w_instr_nxt       = r_instr;
            w_instr_pc_nxt    = r_instr_pc;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_REQ;
        end

        // While reset is held the memory port must not write and the loader
        // must not see a handshake.
        if (reset) begin
            load_ready   = 1'b0;
            imem_rw      = 1'b1;
            imem_data_in = '0;
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Two instances share clock, reset and loader inputs: u_dut (RESET_PC = 0)
// carries the main traffic, u_wrap (RESET_PC = 32'hFFFF_FFFC) always has
// instr_ready high and no redirects so its PC runs across the top of the
// address space. Each instance has its own one-cycle-latency memory model.
//
// The reference model is a program image prog[] plus the PC of the next
// instruction decode should see. The driver pushes that expectation into
// exp_q whenever it issues load_done, completes a handshake or redirects; the
// monitor pops and compares whenever a new instruction becomes valid.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] LOAD_BASE = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_W   = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        load_ready;
    logic [31:0] imem_address;
    logic        imem_rw;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        wr_load_ready;
    logic [31:0] wr_imem_address;
    logic        wr_imem_rw;
    logic [31:0] wr_imem_data_in;
    logic [31:0] wr_imem_data_out;
    logic        wr_instr_valid;
    logic [31:0] wr_instr;
    logic [31:0] wr_instr_pc;

    logic [31:0] mem   [1024];
    logic [31:0] mem_w [1024];
    logic [31:0] prog  [1024];

    exp_t        exp_q[$];
    int unsigned rise_q[$];
    int unsigned cyc;
    logic [31:0] m_next_pc;
    logic [31:0] m_lp;
    logic [31:0] ld_q[$];
    bit          in_fetch;
    int          total;
    int          bad;

    instr_fetch #(.RESET_PC(RESET_PC), .LOAD_BASE(LOAD_BASE)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .imem_address  (imem_address),
        .imem_rw       (imem_rw),
        .imem_data_in  (imem_data_in),
        .imem_data_out (imem_data_out),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    instr_fetch #(.RESET_PC(RESET_W), .LOAD_BASE(LOAD_BASE)) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (wr_load_ready),
        .load_done     (load_done),
        .imem_address  (wr_imem_address),
        .imem_rw       (wr_imem_rw),
        .imem_data_in  (wr_imem_data_in),
        .imem_data_out (wr_imem_data_out),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .instr_valid   (wr_instr_valid),
        .instr_ready   (1'b1),
        .instr         (wr_instr),
        .instr_pc      (wr_instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: write when rw=0, otherwise registered read.
    always @(posedge clk) begin
        if (!imem_rw) mem[imem_address[9:0]] <= imem_data_in;
        else          imem_data_out <= mem[imem_address[9:0]];
    end

    always @(posedge clk) begin
        if (!wr_imem_rw) mem_w[wr_imem_address[9:0]] <= wr_imem_data_in;
        else             wr_imem_data_out <= mem_w[wr_imem_address[9:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = prog[pc[11:2]];
        exp_q.push_back(e);
        m_next_pc = pc + 32'd4;
    endtask

    // One fetch-phase cycle, entered and left at a falling edge.
    task automatic step(input logic rdy, input logic rdir, input logic [31:0] tgt,
                        input bit noise);
        instr_ready    = rdy;
        redirect_valid = rdir;
        redirect_pc    = tgt;
        load_valid     = noise && ($urandom_range(0, 3) == 0);
        load_done      = noise && ($urandom_range(0, 7) == 0);
        load_data      = $urandom;
        if (in_fetch) begin
            if (rdir) begin
                exp_q.delete();
                push_exp(tgt & ~32'd3);
            end else if (rdy && instr_valid) begin
                push_exp(m_next_pc);
            end
        end
        #1;
        if (noise) begin
            check("fetch_rw", {31'd0, imem_rw}, 32'd1);
            check("fetch_load_ready", {31'd0, load_ready}, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !instr_valid; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    // Writes ld_q starting at LOAD_BASE; load_done rides on the last word.
    task automatic load_words(input bit gaps);
        m_lp = LOAD_BASE;
        for (int i = 0; i < ld_q.size(); i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                load_valid     = 1'b0;
                load_done      = 1'b0;
                redirect_valid = 1'($urandom);
                instr_ready    = 1'($urandom);
                #1;
                check("idle_load_ready", {31'd0, load_ready}, 32'd0);
                check("idle_rw", {31'd0, imem_rw}, 32'd1);
                @(negedge clk);
            end
            load_valid     = 1'b1;
            load_data      = ld_q[i];
            load_done      = (i == ld_q.size() - 1);
            redirect_valid = gaps && 1'($urandom);
            redirect_pc    = $urandom;
            instr_ready    = gaps && 1'($urandom);
            #1;
            check("load_ready", {31'd0, load_ready}, 32'd1);
            check("load_rw", {31'd0, imem_rw}, 32'd0);
            check("load_addr", imem_address, {2'b00, m_lp[31:2]});
            check("load_wdata", imem_data_in, ld_q[i]);
            prog[m_lp[11:2]] = ld_q[i];
            m_lp = m_lp + 32'd4;
            if (load_done) push_exp(RESET_PC);
            @(negedge clk);
        end
        load_valid     = 1'b0;
        load_done      = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        in_fetch       = 1'b1;
    endtask

    // Main monitor: compares each newly valid instruction and the held state.
    initial begin : mon_main
        logic        pv;
        logic [31:0] pa;
        exp_t        cur;
        pv  = 1'b0;
        pa  = '0;
        cur = '0;
        cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (instr_valid && !pv) begin
                rise_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", instr_pc, 32'hxxxx_xxxx);
                end else begin
                    cur = exp_q.pop_front();
                    check("instr_pc", instr_pc, cur.pc);
                    check("instr", instr, cur.word);
                end
            end else if (instr_valid && pv) begin
                check("hold_instr_pc", instr_pc, cur.pc);
                check("hold_instr", instr, cur.word);
                check("hold_imem_addr", imem_address, pa);
            end
            pv = instr_valid;
            pa = imem_address;
        end
    end

    // Wrap-instance monitor: k-th instruction after load_done is at
    // RESET_W + 4k (mod 2^32).
    initial begin : mon_wrap
        logic        pv;
        int unsigned wk;
        logic [31:0] epc;
        pv = 1'b0;
        wk = 0;
        forever begin
            @(posedge clk);
            #2;
            if (load_done && !in_fetch && !reset) wk = 0;
            if (wr_instr_valid && !pv) begin
                epc = RESET_W + 32'(4 * wk);
                check("wrap_instr_pc", wr_instr_pc, epc);
                check("wrap_instr", wr_instr, prog[epc[11:2]]);
                wk++;
            end
            pv = wr_instr_valid;
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        total          = 0;
        bad            = 0;
        in_fetch       = 1'b0;
        m_next_pc      = RESET_PC;
        reset          = 1'b1;
        load_valid     = 1'b1;
        load_data      = 32'hDEAD_BEEF;
        load_done      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            prog[i]  = 32'hC0DE_0000 | 32'(i);
            mem[i]   = prog[i];
            mem_w[i] = prog[i];
        end

        // Reset values, with a loader word offered to prove it is ignored.
        repeat (2) @(negedge clk);
        #1;
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_imem_rw", {31'd0, imem_rw}, 32'd1);
        check("rst_imem_data_in", imem_data_in, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;

        // Load then fetch with decode always ready.
        ld_q = '{32'h0016_8693, 32'h0000_0713};
        load_words(1'b0);
        check("imem_word0", mem[0], 32'h0016_8693);
        check("imem_word1", mem[1], 32'h0000_0713);
        rise_q.delete();
        repeat (9) step(1'b1, 1'b0, 32'h0, 1'b0);
        if (rise_q.size() >= 2) check("valid_period", rise_q[1] - rise_q[0], 32'd3);
        else check("valid_period_count", rise_q.size(), 32'd2);

        // Stall five cycles in S_OUT.
        wait_valid();
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect while the read response is due (S_RESP).
        step(1'b1, 1'b0, 32'h0, 1'b0);   // handshake: now in S_REQ
        step(1'b0, 1'b0, 32'h0, 1'b0);   // now in S_RESP
        step(1'b0, 1'b1, 32'h0000_0009, 1'b0);
        wait_valid();

        // Redirect and ready in the same S_OUT cycle.
        step(1'b1, 1'b1, 32'h0000_0020, 1'b0);
        wait_valid();

        // Reset while an instruction is valid.
        reset = 1'b1;
        exp_q.delete();
        in_fetch = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b0;

        // Random load (first word also confirms load_ptr restarted).
        ld_q.delete();
        for (int i = 0; i < 16; i++) ld_q.push_back($urandom);
        load_words(1'b1);

        // Random fetch traffic with redirects and loader noise.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 4) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else tgt = (32'($urandom_range(0, 40)) << 2) | ($urandom & 32'h3);
                step(1'($urandom), 1'b1, tgt, 1'b1);
            end else begin
                step(1'($urandom), 1'b0, 32'h0, 1'b1);
            end
        end

        // Drain: the pending expectation must show up.
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_exp_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
